wb_sched: RTL and testbench

- Writeback scheduler for the 8-bit, 16-entry register file.
- Arbitrates the file's single write port between three result sources (ALU, data memory, LUT) and drives the file's write-control inputs (regWrt, memLd, lutLd, write pointer).
- Keeps a pending-load scoreboard so decode can stall on read-after-load hazards.
- Sits between execute/memory stages and the register file.

---
 rtl/wb_sched_pkg.sv | 23 ++
 rtl/wb_sched_if.sv | 29 ++
 rtl/wb_sched_arb.sv | 89 ++++++++
 rtl/wb_sched.sv | 122 ++++++++++++
 tb/tb_wb_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_sched_pkg.sv
// Shared definitions for the writeback scheduler slice.
// Holds register-file geometry, the writeback source encoding and the
// requester index map used on the arbiter's request/grant vectors.
package wb_sched_pkg;

  localparam int byteW   = 8;   // register-file data width
  localparam int opPtrAW = 4;   // register pointer width
  localparam int NREG    = 16;  // register count, 2**opPtrAW

  // Which source owns the write port this cycle.
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_MEM  = 2'd2,
    WB_LUT  = 2'd3
  } wb_src_e;

  // Bit positions of each requester in the arbiter's req/gnt vectors.
  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;
  localparam int SRC_LUT = 2;

endpackage

// File: rtl/wb_sched_if.sv
// Request/grant bundle between the result sources and the writeback
// scheduler. Each source raises its req with a destination pointer and
// holds both until it sees its gnt.
//   master : result sources (drive req/dst, observe gnt)
//   slave  : wb_sched      (observe req/dst, drive gnt)
interface wb_sched_if;
  import wb_sched_pkg::*;

  logic               alu_req;
  logic [opPtrAW-1:0] alu_dst;
  logic               mem_req;
  logic [opPtrAW-1:0] mem_dst;
  logic               lut_req;
  logic [opPtrAW-1:0] lut_dst;
  logic               alu_gnt;
  logic               mem_gnt;
  logic               lut_gnt;

  modport master (
    output alu_req, alu_dst, mem_req, mem_dst, lut_req, lut_dst,
    input  alu_gnt, mem_gnt, lut_gnt
  );

  modport slave (
    input  alu_req, alu_dst, mem_req, mem_dst, lut_req, lut_dst,
    output alu_gnt, mem_gnt, lut_gnt
  );

endinterface

// File: rtl/wb_sched_arb.sv
// wb_prio_arb: 3-way starvation-aware fixed-priority arbiter.
// Ports:
//   clk, init_n : clock and synchronous active-low reset
//   req[2:0]    : requests, indexed by SRC_ALU/SRC_MEM/SRC_LUT
//   gnt[2:0]    : one-hot combinational grant (zero while init_n=0)
//   src         : granted source as wb_src_e (WB_NONE when idle)
// A requester that has waited STARVE_LIM cycles joins the starved class,
// which always beats the normal class; inside a class mem > lut > alu.
module wb_prio_arb
  import wb_sched_pkg::*;
#(
  parameter int STARVE_LIM = 3
) (
  input  logic       clk,
  input  logic       init_n,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output wb_src_e    src
);

  localparam logic [2:0] LIM = 3'(STARVE_LIM);

  logic [2:0][2:0] wait_r;
  logic [2:0]      starved_s;
  logic [2:0]      gnt_s;
  wb_src_e         src_s;

  // Flag requesters whose wait has reached the promotion threshold.
  always_comb begin
    starved_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      starved_s[i] = req[i] & (wait_r[i] >= LIM);
    end
  end

  // Starved class first, then normal class, each in mem > lut > alu order.
  always_comb begin
    gnt_s = 3'b000;
    src_s = WB_NONE;
    if (!init_n) begin
      gnt_s = 3'b000;
      src_s = WB_NONE;
    end else if (starved_s[SRC_MEM]) begin
      gnt_s[SRC_MEM] = 1'b1;
      src_s          = WB_MEM;
    end else if (starved_s[SRC_LUT]) begin
      gnt_s[SRC_LUT] = 1'b1;
      src_s          = WB_LUT;
    end else if (starved_s[SRC_ALU]) begin
      gnt_s[SRC_ALU] = 1'b1;
      src_s          = WB_ALU;
    end else if (req[SRC_MEM]) begin
      gnt_s[SRC_MEM] = 1'b1;
      src_s          = WB_MEM;
    end else if (req[SRC_LUT]) begin
      gnt_s[SRC_LUT] = 1'b1;
      src_s          = WB_LUT;
    end else if (req[SRC_ALU]) begin
      gnt_s[SRC_ALU] = 1'b1;
      src_s          = WB_ALU;
    end else begin
      gnt_s = 3'b000;
      src_s = WB_NONE;
    end
  end

  // Wait counters: count up (saturating) while refused, clear on grant or idle.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      wait_r <= 9'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (req[i] && !gnt_s[i]) begin
          if (wait_r[i] != 3'd7) begin
            wait_r[i] <= wait_r[i] + 3'd1;
          end else begin
            wait_r[i] <= wait_r[i];
          end
        end else begin
          wait_r[i] <= 3'd0;
        end
      end
    end
  end

  assign gnt = gnt_s;
  assign src = src_s;

endmodule

// File: rtl/wb_sched.sv
// wb_sched: writeback scheduler for the 8-bit, 16-entry register file.
// Ports:
//   clk, init_n          : clock and synchronous active-low reset
//   rq (wb_sched_if)     : ALU / memory / LUT request, dst and grant
//   ld_iss, ld_iss_dst   : load issue notification for the scoreboard
//   rd_ptr_a/b, rd_b_imd : decode read pointers; B ignored when immediate
//   stall                : decode hold, read-after-load hazard
//   reg_wrt, mem_ld, lut_ld, wb_ptr : registered register-file write control
//   pend                 : scoreboard bitmap
//   sb_err               : sticky, load issued to an already-pending register
module wb_sched #(
  parameter int STARVE_LIM = 3,
  parameter int NREG       = 16
) (
  input  logic                              clk,
  input  logic                              init_n,
  wb_sched_if.slave                         rq,
  input  logic                              ld_iss,
  input  logic [wb_sched_pkg::opPtrAW-1:0]  ld_iss_dst,
  input  logic [wb_sched_pkg::opPtrAW-1:0]  rd_ptr_a,
  input  logic [wb_sched_pkg::opPtrAW-1:0]  rd_ptr_b,
  input  logic                              rd_b_imd,
  output logic                              stall,
  output logic                              reg_wrt,
  output logic                              mem_ld,
  output logic                              lut_ld,
  output logic [wb_sched_pkg::opPtrAW-1:0]  wb_ptr,
  output logic [NREG-1:0]                   pend,
  output logic                              sb_err
);
  import wb_sched_pkg::*;

  logic [2:0]         gnt_s;
  wb_src_e            src_s;
  logic [opPtrAW-1:0] wb_dst_s;
  logic [NREG-1:0]    pend_nxt_s;
  logic               sb_err_nxt_s;

  logic               reg_wrt_r;
  logic               mem_ld_r;
  logic               lut_ld_r;
  logic [opPtrAW-1:0] wb_ptr_r;
  logic [NREG-1:0]    pend_r;
  logic               sb_err_r;

  wb_prio_arb #(
    .STARVE_LIM (STARVE_LIM)
  ) u_arb (
    .clk    (clk),
    .init_n (init_n),
    .req    ({rq.lut_req, rq.mem_req, rq.alu_req}),
    .gnt    (gnt_s),
    .src    (src_s)
  );

  assign rq.alu_gnt = gnt_s[SRC_ALU];
  assign rq.mem_gnt = gnt_s[SRC_MEM];
  assign rq.lut_gnt = gnt_s[SRC_LUT];

  // Destination of the granted source; hold the old pointer when idle.
  always_comb begin
    wb_dst_s = wb_ptr_r;
    case (src_s)
      WB_MEM:  wb_dst_s = rq.mem_dst;
      WB_LUT:  wb_dst_s = rq.lut_dst;
      WB_ALU:  wb_dst_s = rq.alu_dst;
      default: wb_dst_s = wb_ptr_r;
    endcase
  end

  // Scoreboard update: clear on load writeback first, then apply a new
  // issue so a same-cycle set wins and is not flagged as a double issue.
  always_comb begin
    pend_nxt_s   = pend_r;
    sb_err_nxt_s = sb_err_r;
    if (src_s == WB_MEM) begin
      pend_nxt_s[rq.mem_dst] = 1'b0;
    end else begin
      pend_nxt_s = pend_r;
    end
    if (ld_iss) begin
      if (pend_nxt_s[ld_iss_dst]) begin
        sb_err_nxt_s = 1'b1;
      end else begin
        sb_err_nxt_s = sb_err_r;
      end
      pend_nxt_s[ld_iss_dst] = 1'b1;
    end else begin
      sb_err_nxt_s = sb_err_r;
    end
  end

  // Registered write control and scoreboard state.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      reg_wrt_r <= 1'b0;
      mem_ld_r  <= 1'b0;
      lut_ld_r  <= 1'b0;
      wb_ptr_r  <= {opPtrAW{1'b0}};
      pend_r    <= {NREG{1'b0}};
      sb_err_r  <= 1'b0;
    end else begin
      reg_wrt_r <= (src_s != WB_NONE);
      mem_ld_r  <= (src_s == WB_MEM);
      lut_ld_r  <= (src_s == WB_LUT);
      wb_ptr_r  <= wb_dst_s;
      pend_r    <= pend_nxt_s;
      sb_err_r  <= sb_err_nxt_s;
    end
  end

  // The pend bit of a register written back this cycle is already clear,
  // so decode resumes without an extra bubble.
  assign stall   = pend_r[rd_ptr_a] | (pend_r[rd_ptr_b] & ~rd_b_imd);
  assign reg_wrt = reg_wrt_r;
  assign mem_ld  = mem_ld_r;
  assign lut_ld  = lut_ld_r;
  assign wb_ptr  = wb_ptr_r;
  assign pend    = pend_r;
  assign sb_err  = sb_err_r;

endmodule

// File: tb/tb_wb_sched.sv
// Self-checking bench for wb_sched: directed scenarios plus a randomized
// run compared against a behavioural scoreboard/priority model.
module tb_wb_sched;

  logic        clk = 1'b0;
  logic        init_n;
  logic        ld_iss;
  logic [3:0]  ld_iss_dst;
  logic [3:0]  rd_ptr_a;
  logic [3:0]  rd_ptr_b;
  logic        rd_b_imd;
  logic        stall;
  logic        reg_wrt;
  logic        mem_ld;
  logic        lut_ld;
  logic [3:0]  wb_ptr;
  logic [15:0] pend;
  logic        sb_err;

  int n_cmp = 0;
  int n_err = 0;

  localparam int LIM   = 3;
  localparam int BOUND = 2 * LIM + 2;

  wb_sched_if bus ();

  wb_sched #(.STARVE_LIM(LIM), .NREG(16)) dut (
    .clk        (clk),
    .init_n     (init_n),
    .rq         (bus),
    .ld_iss     (ld_iss),
    .ld_iss_dst (ld_iss_dst),
    .rd_ptr_a   (rd_ptr_a),
    .rd_ptr_b   (rd_ptr_b),
    .rd_b_imd   (rd_b_imd),
    .stall      (stall),
    .reg_wrt    (reg_wrt),
    .mem_ld     (mem_ld),
    .lut_ld     (lut_ld),
    .wb_ptr     (wb_ptr),
    .pend       (pend),
    .sb_err     (sb_err)
  );

  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.alu_req = 1'b0; bus.mem_req = 1'b0; bus.lut_req = 1'b0;
    ld_iss = 1'b0; rd_ptr_a = 4'd0; rd_ptr_b = 4'd0; rd_b_imd = 1'b0;
  endtask

  task automatic test_reset();
    init_n = 1'b0;
    bus.alu_req = 1'b1; bus.alu_dst = 4'd1;
    bus.mem_req = 1'b1; bus.mem_dst = 4'd2;
    bus.lut_req = 1'b1; bus.lut_dst = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.alu_gnt, bus.mem_gnt, bus.lut_gnt} !== 3'b000) begin
        n_err++; $display("FAIL reset_gnt: got %b expected 000", {bus.alu_gnt, bus.mem_gnt, bus.lut_gnt});
      end
      next_cycle();
    end
    n_cmp++;
    if ({reg_wrt, mem_ld, lut_ld, sb_err, wb_ptr, pend} !== 24'd0) begin
      n_err++; $display("FAIL reset_state: got rw=%b ml=%b ll=%b err=%b ptr=%0d pend=%h expected all 0",
                        reg_wrt, mem_ld, lut_ld, sb_err, wb_ptr, pend);
    end
    init_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.alu_gnt, bus.mem_gnt, bus.lut_gnt} !== 3'b010) begin
      n_err++; $display("FAIL reset_first_gnt: got %b expected 010", {bus.alu_gnt, bus.mem_gnt, bus.lut_gnt});
    end
    next_cycle();
    quiet();
    n_cmp++;
    if ({reg_wrt, mem_ld, lut_ld, wb_ptr} !== {3'b110, 4'd2}) begin
      n_err++; $display("FAIL reset_first_wb: got rw=%b ml=%b ll=%b ptr=%0d expected 1 1 0 2", reg_wrt, mem_ld, lut_ld, wb_ptr);
    end
    next_cycle();
  endtask

  task automatic test_priority();
    logic [2:0] exp_gnt [4] = '{3'b010, 3'b001, 3'b100, 3'b000};
    logic [3:0] exp_ptr [4] = '{4'd5, 4'd7, 4'd3, 4'd3};
    logic [2:0] exp_ctl [4] = '{3'b110, 3'b101, 3'b100, 3'b000};
    bus.alu_req = 1'b1; bus.alu_dst = 4'd3;
    bus.mem_req = 1'b1; bus.mem_dst = 4'd5;
    bus.lut_req = 1'b1; bus.lut_dst = 4'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.alu_gnt, bus.mem_gnt, bus.lut_gnt} !== exp_gnt[i]) begin
        n_err++; $display("FAIL prio_gnt[%0d]: got %b expected %b", i, {bus.alu_gnt, bus.mem_gnt, bus.lut_gnt}, exp_gnt[i]);
      end
      next_cycle();
      if (bus.mem_gnt) bus.mem_req = 1'b0;
      if (bus.lut_gnt) bus.lut_req = 1'b0;
      if (bus.alu_gnt) bus.alu_req = 1'b0;
      n_cmp++;
      if ({reg_wrt, mem_ld, lut_ld} !== exp_ctl[i] || wb_ptr !== exp_ptr[i]) begin
        n_err++; $display("FAIL prio_wb[%0d]: got ctl=%b ptr=%0d expected ctl=%b ptr=%0d",
                          i, {reg_wrt, mem_ld, lut_ld}, wb_ptr, exp_ctl[i], exp_ptr[i]);
      end
    end
    quiet();
  endtask

  task automatic test_starvation();
    int got;
    // mem re-requests every cycle; alu must be promoted after LIM refusals.
    bus.alu_req = 1'b1; bus.alu_dst = 4'd6;
    bus.mem_req = 1'b1; bus.mem_dst = 4'd1;
    for (int k = 0; k <= LIM; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.alu_gnt, bus.mem_gnt} !== ((k < LIM) ? 2'b01 : 2'b10)) begin
        n_err++; $display("FAIL starve_mem_only[%0d]: got alu/mem %b expected %b",
                          k, {bus.alu_gnt, bus.mem_gnt}, (k < LIM) ? 2'b01 : 2'b10);
      end
      next_cycle();
    end
    quiet();
    next_cycle();
    // mem and lut both re-request every cycle; alu still served within bound.
    bus.alu_req = 1'b1; bus.mem_req = 1'b1; bus.lut_req = 1'b1; bus.lut_dst = 4'd8;
    got = -1;
    for (int k = 0; k <= BOUND && got < 0; k++) begin
      @(negedge clk);
      if (bus.alu_gnt) got = k;
      next_cycle();
    end
    n_cmp++;
    if (got < 0) begin
      n_err++; $display("FAIL starve_bound: got no alu grant expected within %0d cycles", BOUND);
    end
    quiet();
    next_cycle();
  endtask

  task automatic test_hazard();
    ld_iss = 1'b1; ld_iss_dst = 4'd9;
    next_cycle();
    ld_iss = 1'b0; rd_ptr_a = 4'd9;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (stall !== 1'b1) begin
        n_err++; $display("FAIL hazard_stall[%0d]: got %b expected 1", k, stall);
      end
      next_cycle();
    end
    bus.mem_req = 1'b1; bus.mem_dst = 4'd9;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_gnt, stall} !== 2'b11) begin
      n_err++; $display("FAIL hazard_gnt_cycle: got gnt/stall %b expected 11", {bus.mem_gnt, stall});
    end
    next_cycle();
    bus.mem_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({stall, pend[9], reg_wrt, mem_ld, wb_ptr} !== {4'b0011, 4'd9}) begin
      n_err++; $display("FAIL hazard_release: got stall=%b pend9=%b rw=%b ml=%b ptr=%0d expected 0 0 1 1 9",
                        stall, pend[9], reg_wrt, mem_ld, wb_ptr);
    end
    next_cycle();
    ld_iss = 1'b1; ld_iss_dst = 4'd9;
    next_cycle();
    ld_iss = 1'b0; rd_ptr_a = 4'd0; rd_ptr_b = 4'd9; rd_b_imd = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b0) begin
      n_err++; $display("FAIL hazard_imd: got %b expected 0", stall);
    end
    next_cycle();
    rd_b_imd = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (stall !== 1'b1) begin
      n_err++; $display("FAIL hazard_ptr_b: got %b expected 1", stall);
    end
    next_cycle();
    bus.mem_req = 1'b1; bus.mem_dst = 4'd9;
    next_cycle();
    quiet();
    next_cycle();
  endtask

  task automatic test_simul_set_clear();
    ld_iss = 1'b1; ld_iss_dst = 4'd4;
    next_cycle();
    bus.mem_req = 1'b1; bus.mem_dst = 4'd4;
    @(negedge clk);
    n_cmp++;
    if (bus.mem_gnt !== 1'b1) begin
      n_err++; $display("FAIL simul_gnt: got %b expected 1", bus.mem_gnt);
    end
    next_cycle();
    quiet();
    n_cmp++;
    if ({pend[4], sb_err} !== 2'b10) begin
      n_err++; $display("FAIL simul_pend: got pend4=%b err=%b expected 1 0", pend[4], sb_err);
    end
    bus.mem_req = 1'b1;
    next_cycle();
    bus.mem_req = 1'b0;
    n_cmp++;
    if (pend !== 16'h0000) begin
      n_err++; $display("FAIL simul_clear: got %h expected 0000", pend);
    end
  endtask

  task automatic test_double_issue();
    ld_iss = 1'b1; ld_iss_dst = 4'd2;
    next_cycle();
    next_cycle();
    ld_iss = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({sb_err, pend[2]} !== 2'b11) begin
        n_err++; $display("FAIL double_err[%0d]: got err=%b pend2=%b expected 1 1", k, sb_err, pend[2]);
      end
      next_cycle();
    end
    init_n = 1'b0;
    next_cycle();
    init_n = 1'b1;
    n_cmp++;
    if ({sb_err, pend} !== 17'd0) begin
      n_err++; $display("FAIL double_reset: got err=%b pend=%h expected 0 0000", sb_err, pend);
    end
  endtask

  // Random traffic against a model built from the scheduling rules.
  // Requester index 0=mem 1=lut 2=alu (priority order).
  task automatic test_random();
    bit          hold [3];
    logic [3:0]  dst  [3];
    int          wt   [3];
    int          age  [3];
    logic [15:0] m_pend = 16'h0;
    logic        m_err = 1'b0, m_rw = 1'b0, m_ml = 1'b0, m_ll = 1'b0;
    logic [3:0]  m_ptr = 4'd0;
    logic [2:0]  exp_gnt;
    logic        exp_stall;
    bit          rst_now;
    int          g;
    for (int i = 0; i < 3; i++) begin hold[i] = 1'b0; dst[i] = 4'd0; wt[i] = 0; age[i] = 0; end
    for (int cyc = 0; cyc < 450; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i]) begin
          if ($urandom_range(0, 7) == 0) begin hold[i] = 1'b0; age[i] = 0; end
        end else if ($urandom_range(0, 1) == 1) begin
          hold[i] = 1'b1; dst[i] = 4'($urandom_range(0, 15));
        end
      end
      rst_now    = (cyc % 150 == 149);
      init_n     = !rst_now;
      ld_iss     = ($urandom_range(0, 3) == 0);
      ld_iss_dst = 4'($urandom_range(0, 15));
      rd_ptr_a   = 4'($urandom_range(0, 15));
      rd_ptr_b   = 4'($urandom_range(0, 15));
      rd_b_imd   = 1'($urandom_range(0, 1));
      bus.mem_req = hold[0]; bus.mem_dst = dst[0];
      bus.lut_req = hold[1]; bus.lut_dst = dst[1];
      bus.alu_req = hold[2]; bus.alu_dst = dst[2];
      g = -1;
      if (!rst_now) begin
        for (int i = 0; i < 3; i++) if (g < 0 && hold[i] && wt[i] >= LIM) g = i;
        for (int i = 0; i < 3; i++) if (g < 0 && hold[i]) g = i;
      end
      exp_gnt   = {g == 2, g == 0, g == 1};
      exp_stall = m_pend[rd_ptr_a] | (m_pend[rd_ptr_b] & ~rd_b_imd);
      @(negedge clk);
      n_cmp++;
      if ({bus.alu_gnt, bus.mem_gnt, bus.lut_gnt} !== exp_gnt || stall !== exp_stall) begin
        n_err++; $display("FAIL rand_comb[%0d]: got gnt=%b stall=%b expected gnt=%b stall=%b",
                          cyc, {bus.alu_gnt, bus.mem_gnt, bus.lut_gnt}, stall, exp_gnt, exp_stall);
      end
      next_cycle();
      if (rst_now) begin
        for (int i = 0; i < 3; i++) begin wt[i] = 0; age[i] = 0; end
        m_pend = 16'h0; m_err = 1'b0; m_rw = 1'b0; m_ml = 1'b0; m_ll = 1'b0; m_ptr = 4'd0;
      end else begin
        for (int i = 0; i < 3; i++) wt[i] = (hold[i] && g != i) ? ((wt[i] < 7) ? wt[i] + 1 : 7) : 0;
        m_rw = (g >= 0); m_ml = (g == 0); m_ll = (g == 1);
        if (g >= 0) m_ptr = dst[g];
        if (g == 0) m_pend[dst[0]] = 1'b0;
        if (ld_iss) begin
          if (m_pend[ld_iss_dst]) m_err = 1'b1;
          m_pend[ld_iss_dst] = 1'b1;
        end
      end
      n_cmp++;
      if ({reg_wrt, mem_ld, lut_ld} !== {m_rw, m_ml, m_ll} || wb_ptr !== m_ptr ||
          pend !== m_pend || sb_err !== m_err) begin
        n_err++; $display("FAIL rand_regs[%0d]: got ctl=%b ptr=%0d pend=%h err=%b expected ctl=%b ptr=%0d pend=%h err=%b",
                          cyc, {reg_wrt, mem_ld, lut_ld}, wb_ptr, pend, sb_err,
                          {m_rw, m_ml, m_ll}, m_ptr, m_pend, m_err);
      end
      if (g >= 0) begin hold[g] = 1'b0; age[g] = 0; end
      for (int i = 0; i < 3; i++) begin
        if (hold[i]) begin
          age[i]++;
          n_cmp++;
          if (age[i] > BOUND) begin
            n_err++; $display("FAIL rand_latency[%0d]: got wait %0d on requester %0d expected at most %0d",
                              cyc, age[i], i, BOUND);
          end
        end
      end
    end
    init_n = 1'b1;
    quiet();
    next_cycle();
  endtask

  initial begin
    init_n = 1'b0;
    bus.alu_dst = 4'd0; bus.mem_dst = 4'd0; bus.lut_dst = 4'd0;
    ld_iss_dst = 4'd0;
    quiet();
    test_reset();
    test_priority();
    test_starvation();
    test_hazard();
    test_simul_set_clear();
    test_double_issue();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
